// File: rtl/alu_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_pkg: opcodes, flag indices and FSM encoding for the ALU slice  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_INC = 3'b010;
  localparam logic [2:0] OP_DEC = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_NOT = 3'b111;

  localparam int FLG_Z = 3;
  localparam int FLG_C = 2;
  localparam int FLG_V = 1;
  localparam int FLG_N = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic [3:0] pack_flags(input logic z, input logic c,
                                            input logic v, input logic n);
    logic [3:0] f;
    f        = 4'b0000;
    f[FLG_Z] = z;
    f[FLG_C] = c;
    f[FLG_V] = v;
    f[FLG_N] = n;
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_4bit.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_4bit: combinational ALU with Z/C/V/N flags (C = borrow on sub) |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module alu_4bit
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       opcode,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             negative
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH:0]   ext;
  logic [WIDTH-1:0] rhs;

  always_comb begin
    ext      = '0;
    rhs      = '0;
    result   = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    case (opcode)
      OP_ADD, OP_INC: begin
        rhs      = (opcode == OP_INC) ? WIDTH'(1) : b;
        ext      = {1'b0, a} + {1'b0, rhs};
        result   = ext[WIDTH-1:0];
        carry    = ext[WIDTH];
        overflow = (a[MSB] == rhs[MSB]) && (result[MSB] != a[MSB]);
      end
      OP_SUB, OP_DEC: begin
        // the extra top bit of the wide difference is the borrow
        rhs      = (opcode == OP_DEC) ? WIDTH'(1) : b;
        ext      = {1'b0, a} - {1'b0, rhs};
        result   = ext[WIDTH-1:0];
        carry    = ext[WIDTH];
        overflow = (a[MSB] != rhs[MSB]) && (result[MSB] != a[MSB]);
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      default: result = ~a;
    endcase
  end

  assign zero     = (result == '0);
  assign negative = result[MSB];

endmodule
`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_cmd_sequencer: repeats ALU ops on an accumulator, returns flags |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_load,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [REP_W-1:0] cmd_rep,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_opcode,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_carry,
  input  logic             alu_overflow,
  input  logic             alu_negative,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [3:0]       rsp_flags,
  output logic             rsp_sticky_c,
  output logic             rsp_sticky_v,
  output logic [WIDTH-1:0] acc_out
);

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] b_reg;
  logic [2:0]       op_reg;
  logic [REP_W-1:0] cnt;
  logic [3:0]       flags;
  logic             sticky_c;
  logic             sticky_v;
  logic             rsp_valid_r;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      acc         <= '0;
      b_reg       <= '0;
      op_reg      <= '0;
      cnt         <= '0;
      flags       <= '0;
      sticky_c    <= 1'b0;
      sticky_v    <= 1'b0;
      rsp_valid_r <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_reg   <= cmd_op;
            b_reg    <= cmd_b;
            cnt      <= cmd_rep;
            sticky_c <= 1'b0;
            sticky_v <= 1'b0;
            if (cmd_load) begin
              // a load bypasses the ALU, so its flags are derived here
              acc         <= cmd_b;
              flags       <= pack_flags(cmd_b == '0, 1'b0, 1'b0, cmd_b[WIDTH-1]);
              rsp_valid_r <= 1'b1;
              state       <= ST_RESP;
            end else begin
              state <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          acc      <= alu_result;
          flags    <= pack_flags(alu_zero, alu_carry, alu_overflow, alu_negative);
          sticky_c <= sticky_c | alu_carry;
          sticky_v <= sticky_v | alu_overflow;
          if (cnt == '0) begin
            rsp_valid_r <= 1'b1;
            state       <= ST_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: begin
          rsp_valid_r <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

  // rst_n gates ready directly so no command can slip in during reset
  assign cmd_ready    = rst_n && (state == ST_IDLE);
  assign alu_a        = acc;
  assign alu_b        = b_reg;
  assign alu_opcode   = op_reg;
  assign rsp_valid    = rsp_valid_r;
  assign rsp_result   = acc;
  assign rsp_flags    = flags;
  assign rsp_sticky_c = sticky_c;
  assign rsp_sticky_v = sticky_v;
  assign acc_out      = acc;

endmodule
`default_nettype wire
